mealy_sd_overlapping: RTL and testbench
=======================================

Name: mealy_sd_overlapping

Overview:
- Mealy finite-state machine that detects the serial bit pattern 1-1-0-1-0-1 on a 1-bit input stream, with overlap allowed.
- One input bit is sampled per clock.
- Output y is a combinational Mealy output. It is high in the same cycle that the final '1' of the pattern is present on x.
- Used as a leaf serial-pattern detector feeding control logic.

Parameters:
- CNT_W, 8, width of the optional detection counter (used only when SD_DETECT_COUNT_EN is defined).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- x  input  1  serial data bit, sampled on rising clk.
- y  output  1  detection flag; 1 when the current state is F and x=1.
- det_count  output  CNT_W  number of detections; exists only with SD_DETECT_COUNT_EN.

Behaviour:
- State register is named cs, 3 bits wide; the next-state signal is named ns.
- Encoding:
  - A=3'b000: idle / no prefix.
  - B=3'b001: "1".
  - C=3'b010: "11".
  - D=3'b011: "110".
  - E=3'b100: "1101".
  - F=3'b101: "11010".
- Codes 110 and 111 are illegal: ns=A and y=0.
- Transitions, written as state: x=0 -> next, x=1 -> next:
  - A: 0->A, 1->B.
  - B: 0->A, 1->C.
  - C: 0->D, 1->C (longest suffix "11" is kept).
  - D: 0->A, 1->E.
  - E: 0->F, 1->C ("11011" keeps suffix "11").
  - F: 0->A, 1->B, and y=1 (pattern complete; the trailing "1" restarts the match).
- y = (cs==F) && x, purely combinational, with no register on the output. Detection therefore has zero cycles of latency relative to the sampled bit.
- y is 1 only in state F with x=1; in every other state and input combination y=0.
- The state register updates on the rising edge of clk with cs <= ns.
- Reset:
  - reset=0 forces cs=A immediately, independent of clk. Consequently y=0 while reset is low.
  - Reset asserted mid-sequence discards all partial-match history.
  - After reset deasserts, the first rising edge samples x from state A.
- Back-to-back patterns: after a detection the FSM is in B, so "1101011010 1" yields a second detection without returning to A.
- No handshake, no enable: every rising edge consumes one bit.

Optional Feature:
- Macro SD_DETECT_COUNT_EN.
- Defined:
  - Adds output det_count[CNT_W-1:0], a registered counter incremented on each rising edge where y=1 (cs==F and x==1).
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared to 0 by asynchronous reset.
- Not defined:
  - No det_count port and no counter logic.
  - The y/cs behaviour is identical in both builds.

Test Plan:
- Reset sequencing: hold reset=0 with x toggling -> cs=000 and y=0 throughout. Release reset=1, feed x=0 for 3 clocks -> cs stays 000.
- Exact pattern: from A feed 1,1,0,1,0,1 -> cs goes B,C,D,E,F. y=1 only while cs=F and x=1; next cs=B. With SD_DETECT_COUNT_EN, det_count=1.
- Overlap: after the previous detection (cs=B) feed 1,0,1,0,1 -> cs goes C,D,E,F, and a second y=1 pulse fires on the last bit; det_count=2.
- No match: feed 0,1,0,0,1,1 -> cs goes A,B,A,A,B,C; y stays 0.
- Broken prefix: feed 1,1,0,1,1,0,1,0,1 -> E then x=1 returns to C (not A). The sequence continues D,E,F, and a detection pulse fires on the final bit; next cs=B.
- Asynchronous reset mid-operation: reach cs=F, hold x=1, drive reset=0 between clock edges -> cs=000 and y=0 immediately, with no detection counted.

Source files
------------

// File: rtl/mealy_sd_overlapping.sv
// Overlapping Mealy detector for the serial pattern 1-1-0-1-0-1; y is combinational.
// Define SD_DETECT_COUNT_EN to add the det_count detection counter.
module mealy_sd_overlapping
`ifdef SD_DETECT_COUNT_EN
  #(parameter int CNT_W = 8)
`endif
  (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
`ifdef SD_DETECT_COUNT_EN
  output logic [CNT_W-1:0] det_count,
`endif
  output logic             y
);

  // state | meaning
  // A     | idle / no prefix
  // B     | "1"
  // C     | "11"
  // D     | "110"
  // E     | "1101"
  // F     | "11010"
  typedef enum logic [2:0] {
    A = 3'b000,
    B = 3'b001,
    C = 3'b010,
    D = 3'b011,
    E = 3'b100,
    F = 3'b101
  } state_t;

  state_t cs;
  state_t ns;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs <= A;
    end else begin
      cs <= ns;
    end
  end

  always_comb begin
    ns = A;
    y  = 1'b0;
    case (cs)
      A: ns = x ? B : A;
      B: ns = x ? C : A;
      C: ns = x ? C : D;
      D: ns = x ? E : A;
      // "11011" still ends in "11", so fall back to C rather than A
      E: ns = x ? C : F;
      F: begin
        ns = x ? B : A;
        y  = x;
      end
      default: begin
        ns = A;
        y  = 1'b0;
      end
    endcase
  end

`ifdef SD_DETECT_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_count <= '0;
    end else if (y) begin
      det_count <= det_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mealy_sd_overlapping.sv
// Directed bench for mealy_sd_overlapping; expectations queued at drive time, checked as the DUT responds.
module tb_mealy_sd_overlapping;

  logic       clk;
  logic       reset;
  logic       x;
  logic       y;
`ifdef SD_DETECT_COUNT_EN
  logic [7:0] det_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       y;
    logic [2:0] cs;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [2:0] S_A = 3'b000;
  localparam logic [2:0] S_B = 3'b001;
  localparam logic [2:0] S_C = 3'b010;
  localparam logic [2:0] S_D = 3'b011;
  localparam logic [2:0] S_E = 3'b100;
  localparam logic [2:0] S_F = 3'b101;

  mealy_sd_overlapping dut (
    .clk      (clk),
    .reset    (reset),
    .x        (x),
`ifdef SD_DETECT_COUNT_EN
    .det_count(det_count),
`endif
    .y        (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_y(input string tag, input logic exp_y);
    total++;
    assert (y === exp_y) else begin
      bad++;
      $error("FAIL %s y: observed=%b expected=%b", tag, y, exp_y);
    end
  endtask

  task automatic check_cs(input string tag, input logic [2:0] exp_cs);
    total++;
    assert (3'(dut.cs) === exp_cs) else begin
      bad++;
      $error("FAIL %s cs: observed=%b expected=%b", tag, 3'(dut.cs), exp_cs);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [7:0] exp_cnt);
`ifdef SD_DETECT_COUNT_EN
    total++;
    assert (det_count === exp_cnt) else begin
      bad++;
      $error("FAIL %s det_count: observed=%0d expected=%0d", tag, det_count, exp_cnt);
    end
`else
    if (exp_cnt === 8'hxx) $display("unused count");
`endif
  endtask

  // Drive one bit at the falling edge; y is checked before the rising edge, cs just after it.
  task automatic step(input string tag, input logic b, input logic exp_y, input logic [2:0] exp_cs);
    exp_t e;
    exp_t got;
    @(negedge clk);
    x    = b;
    e.y  = exp_y;
    e.cs = exp_cs;
    exp_q.push_back(e);
    #1;
    got = exp_q[0];
    check_y(tag, got.y);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_cs(tag, got.cs);
  endtask

  initial begin
    reset = 1'b0;
    x     = 1'b0;

    // Reset held low: x toggles across clock edges, FSM must stay in A with y low
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x = ~x;
      #1;
      check_y("rst_hold", 1'b0);
      @(posedge clk);
      #1;
      check_cs("rst_hold", S_A);
    end
    check_cnt("rst_hold", 8'd0);

    @(negedge clk);
    reset = 1'b1;
    x     = 1'b0;

    step("idle0", 1'b0, 1'b0, S_A);
    step("idle1", 1'b0, 1'b0, S_A);
    step("idle2", 1'b0, 1'b0, S_A);

    // Exact pattern
    step("pat1", 1'b1, 1'b0, S_B);
    step("pat2", 1'b1, 1'b0, S_C);
    step("pat3", 1'b0, 1'b0, S_D);
    step("pat4", 1'b1, 1'b0, S_E);
    step("pat5", 1'b0, 1'b0, S_F);
    step("pat6", 1'b1, 1'b1, S_B);
    check_cnt("pat", 8'd1);

    // Overlapping second detection from B
    step("ovl1", 1'b1, 1'b0, S_C);
    step("ovl2", 1'b0, 1'b0, S_D);
    step("ovl3", 1'b1, 1'b0, S_E);
    step("ovl4", 1'b0, 1'b0, S_F);
    step("ovl5", 1'b1, 1'b1, S_B);
    check_cnt("ovl", 8'd2);

    // No match
    step("nom1", 1'b0, 1'b0, S_A);
    step("nom2", 1'b1, 1'b0, S_B);
    step("nom3", 1'b0, 1'b0, S_A);
    step("nom4", 1'b0, 1'b0, S_A);
    step("nom5", 1'b1, 1'b0, S_B);
    step("nom6", 1'b1, 1'b0, S_C);
    step("c_hold", 1'b1, 1'b0, S_C);
    step("to_d", 1'b0, 1'b0, S_D);
    step("to_a", 1'b0, 1'b0, S_A);
    check_cnt("nom", 8'd2);

    // Broken prefix: E with x=1 falls back to C
    step("brk1", 1'b1, 1'b0, S_B);
    step("brk2", 1'b1, 1'b0, S_C);
    step("brk3", 1'b0, 1'b0, S_D);
    step("brk4", 1'b1, 1'b0, S_E);
    step("brk5", 1'b1, 1'b0, S_C);
    step("brk6", 1'b0, 1'b0, S_D);
    step("brk7", 1'b1, 1'b0, S_E);
    step("brk8", 1'b0, 1'b0, S_F);
    step("brk9", 1'b1, 1'b1, S_B);
    check_cnt("brk", 8'd3);

    // F with x=0 returns to A without a detection
    step("f0_1", 1'b1, 1'b0, S_C);
    step("f0_2", 1'b0, 1'b0, S_D);
    step("f0_3", 1'b1, 1'b0, S_E);
    step("f0_4", 1'b0, 1'b0, S_F);
    step("f0_5", 1'b0, 1'b0, S_A);
    check_cnt("f0", 8'd3);

    // Async reset while in F with x=1
    step("ar1", 1'b1, 1'b0, S_B);
    step("ar2", 1'b1, 1'b0, S_C);
    step("ar3", 1'b0, 1'b0, S_D);
    step("ar4", 1'b1, 1'b0, S_E);
    step("ar5", 1'b0, 1'b0, S_F);
    @(negedge clk);
    x = 1'b1;
    #1;
    check_y("ar_pre", 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check_cs("ar_now", S_A);
    check_y("ar_now", 1'b0);
    check_cnt("ar_now", 8'd0);
    @(posedge clk);
    #1;
    check_cs("ar_edge", S_A);
    check_y("ar_edge", 1'b0);
    check_cnt("ar_edge", 8'd0);
    @(negedge clk);
    reset = 1'b1;
    step("post1", 1'b0, 1'b0, S_A);
    step("post2", 1'b1, 1'b0, S_B);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_empty: observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
